// File: rtl/hough_scan_ctrl.sv
// Hough frame-pass sequencer: accumulator clear sweep, raster X/Y tracking with strobe
// checking, edge thresholding into a small FIFO. Optional ROI gating via HOUGH_ROI_EN.
module hough_scan_ctrl #(
    parameter int          WIDTH      = 640,
    parameter int          HEIGHT     = 480,
    parameter int          XW         = 10,
    parameter int          YW         = 9,
    parameter logic [7:0]  THRESH     = 8'd128,
    parameter int          CLR_AW     = 12,
    parameter int          FIFO_DEPTH = 4,
    parameter int          ROI_X0     = 0,
    parameter int          ROI_X1     = WIDTH - 1
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Start,
    input  logic [7:0]        Pixel,
    input  logic              PixValid,
    input  logic              Frame,
    input  logic              Line,
    output logic              ClrWe,
    output logic [CLR_AW-1:0] ClrAddr,
    output logic              EdgeValid,
    output logic [XW-1:0]     EdgeX,
    output logic [YW-1:0]     EdgeY,
    input  logic              EdgeReady,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic              FrameErr
);
    localparam int              PW   = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0]   XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0]   YMAX = YW'(HEIGHT - 1);
    localparam logic [PW:0]     FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_FRAME, SCAN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CLR_AW-1:0]  clr_addr;
    logic [XW-1:0]      x, ex, x_nxt;   // x/y hold the predicted coordinate of the next pixel
    logic [YW-1:0]      y, ey, y_nxt;
    logic               proc, last, strobe_err, in_roi, push, pop, wr_ok, full, empty;
    logic [XW+YW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]      wptr, rptr;
    logic [PW:0]        cnt;

    // Coordinate assigned to the current pixel, after any strobe resync
    always_comb begin
        proc       = 1'b0;
        strobe_err = 1'b0;
        ex         = x;
        ey         = y;
        if (PixValid) begin
            if (state == WAIT_FRAME && Frame) begin
                proc = 1'b1;
                ex   = '0;
                ey   = '0;
            end else if (state == SCAN) begin
                proc = 1'b1;
                if (Frame) begin
                    strobe_err = 1'b1;
                    ex         = '0;
                    ey         = '0;
                end else if (Line && x != '0) begin
                    strobe_err = 1'b1;
                    ex         = '0;
                    ey         = (y == YMAX) ? '0 : y + YW'(1);
                end else if (!Line && x == '0) begin
                    strobe_err = 1'b1;
                end
            end
        end
    end

    assign last  = proc && ex == XMAX && ey == YMAX;
    assign x_nxt = (ex == XMAX) ? '0 : ex + XW'(1);
    assign y_nxt = (ex == XMAX) ? ((ey == YMAX) ? '0 : ey + YW'(1)) : ey;

`ifdef HOUGH_ROI_EN
    assign in_roi = (int'(ex) >= ROI_X0) && (int'(ex) <= ROI_X1);
`else
    logic unused_roi;
    assign unused_roi = ^{ROI_X0[0], ROI_X1[0]};
    assign in_roi     = 1'b1;
`endif

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL);
    assign push  = proc && (Pixel >= THRESH) && in_roi;
    assign pop   = !empty && EdgeReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state    <= IDLE;
            clr_addr <= '0;
            x        <= '0;
            y        <= '0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            Overflow <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_addr <= (state == CLEAR) ? clr_addr + CLR_AW'(1) : '0;
            if (proc) begin
                x <= x_nxt;
                y <= y_nxt;
            end
            if (state == IDLE && Start) begin
                Overflow <= 1'b0;
                FrameErr <= 1'b0;
            end else begin
                if (push && full && !pop) Overflow <= 1'b1;
                if (strobe_err)           FrameErr <= 1'b1;
            end
            if (wr_ok) wptr <= wptr + PW'(1);
            if (pop)   rptr <= rptr + PW'(1);
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + (PW + 1)'(1);
                2'b01:   cnt <= cnt - (PW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_ok) mem[wptr] <= {ex, ey};
    end

    assign EdgeValid = !empty;
    assign EdgeX     = empty ? '0 : mem[rptr][XW+YW-1:YW];
    assign EdgeY     = empty ? '0 : mem[rptr][YW-1:0];

    always_comb begin
        state_nxt = state;
        ClrWe     = 1'b0;
        ClrAddr   = clr_addr;
        Busy      = (state != IDLE);
        Done      = 1'b0;
        case (state)
            IDLE:       if (Start) state_nxt = CLEAR;
            CLEAR: begin
                ClrWe = 1'b1;
                if (clr_addr == '1) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: if (proc) state_nxt = last ? DRAIN : SCAN;
            SCAN:       if (last) state_nxt = DRAIN;
            DRAIN:      if (empty) state_nxt = DONE;
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default:    state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hough_scan_ctrl.sv
// Self-checking bench for hough_scan_ctrl on a 4x2 raster: queue-based edge model,
// randomized pixels/backpressure/gaps, plus the directed clear/overflow/strobe/reset cases.
module tb_hough_scan_ctrl;
    localparam int W = 4, H = 2, XW = 2, YW = 1, CAW = 3, DEPTH = 4;

    logic           Clk = 1'b0, nReset = 1'b0, Start = 1'b0;
    logic [7:0]     Pixel = '0;
    logic           PixValid = 1'b0, Frame = 1'b0, Line = 1'b0, EdgeReady = 1'b0;
    logic           ClrWe, EdgeValid, Busy, Done, Overflow, FrameErr;
    logic [CAW-1:0] ClrAddr;
    logic [XW-1:0]  EdgeX;
    logic [YW-1:0]  EdgeY;

    int n_chk = 0, n_err = 0, n_pops = 0, done_cnt = 0;
    logic [XW+YW-1:0] q[$];
    logic [XW+YW-1:0] last_pop;
    bit m_ovf = 0;

    hough_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .THRESH(8'd128),
                      .CLR_AW(CAW), .FIFO_DEPTH(DEPTH), .ROI_X0(1), .ROI_X1(2)) dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .Pixel(Pixel), .PixValid(PixValid),
        .Frame(Frame), .Line(Line), .ClrWe(ClrWe), .ClrAddr(ClrAddr), .EdgeValid(EdgeValid),
        .EdgeX(EdgeX), .EdgeY(EdgeY), .EdgeReady(EdgeReady), .Busy(Busy), .Done(Done),
        .Overflow(Overflow), .FrameErr(FrameErr));

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            done_cnt++;
            n_chk++;
            if (Busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_during_done: got %b want 1", Busy);
            end
        end
    end

    function automatic bit roi_ok(input int x);
`ifdef HOUGH_ROI_EN
        return x >= 1 && x <= 2;
`else
        return x >= 0;
`endif
    endfunction

    // One clock: drive inputs, check the FIFO head against the model, advance the model.
    task automatic cyc(input logic pv, input logic fr, input logic ln, input logic [7:0] px,
                       input logic rdy, input bit proc, input int ex, input int ey);
        bit pop;
        PixValid = pv; Frame = fr; Line = ln; Pixel = px; EdgeReady = rdy;
        n_chk++;
        if (EdgeValid !== (q.size() > 0)) begin
            n_err++;
            $display("FAIL edge_valid: got %b want %b", EdgeValid, q.size() > 0);
        end
        pop = (q.size() > 0) && rdy;
        if (pop) begin
            n_chk++;
            if ({EdgeX, EdgeY} !== q[0]) begin
                n_err++;
                $display("FAIL edge_head: got x=%0d y=%0d want x=%0d y=%0d",
                         EdgeX, EdgeY, q[0][XW+YW-1:YW], q[0][YW-1:0]);
            end
            last_pop = q.pop_front();
            n_pops++;
        end
        if (proc && px >= 8'd128 && roi_ok(ex)) begin
            if (q.size() < DEPTH || pop) q.push_back({XW'(ex), YW'(ey)});
            else m_ovf = 1;
        end
        @(posedge Clk); #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, rdy, 0, 0, 0);
    endtask

    task automatic do_reset();
        nReset = 1'b0; PixValid = 1'b1; Pixel = 8'hFF; Frame = 1'b0; Line = 1'b0; Start = 1'b0;
        @(posedge Clk); #1;
        nReset = 1'b1; PixValid = 1'b0;
        q.delete(); m_ovf = 0;
    endtask

    task automatic start_pass();
        Start = 1'b1;
        idle(1'b0);
        Start = 1'b0;
        m_ovf = 0;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (ClrWe !== 1'b1 || ClrAddr !== CAW'(i) || Overflow !== 1'b0 || FrameErr !== 1'b0) begin
                n_err++;
                $display("FAIL clear_sweep: got we=%b addr=%0d ovf=%b ferr=%b want we=1 addr=%0d ovf=0 ferr=0",
                         ClrWe, ClrAddr, Overflow, FrameErr, i);
            end
            if (i < 7) idle(1'b0);
        end
        idle(1'b0);
        n_chk++;
        if (ClrWe !== 1'b0 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL clear_end: got we=%b busy=%b want we=0 busy=1", ClrWe, Busy);
        end
    endtask

    function automatic logic rdy_of(input int mode);
        return (mode == 2) ? logic'($urandom_range(1)) : logic'(mode == 1);
    endfunction

    // mode 0: only (2,1)=C0; mode 1: all FF; mode 2: random. rmode: 0 stall, 1 ready, 2 random.
    task automatic send_frame(input int mode, input int rmode, input bit gaps);
        logic [7:0] px;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                while (gaps && $urandom_range(3) == 0) idle(rdy_of(rmode));
                px = (mode == 0) ? ((x == 2 && y == 1) ? 8'hC0 : 8'h10) :
                     (mode == 1) ? 8'hFF : 8'($urandom_range(255));
                cyc(1'b1, x == 0 && y == 0, x == 0, px, rdy_of(rmode), 1, x, y);
            end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 40) begin idle(1'b1); n++; end
        n_chk++;
        if (done_cnt != d0 + 1 || q.size() != 0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: got dones=%0d busy=%b done=%b left=%0d want dones=1 busy=0 done=0 left=0",
                     done_cnt - d0, Busy, Done, q.size());
        end
        repeat (3) idle(1'b1);
        n_chk++;
        if (done_cnt != d0 + 1) begin
            n_err++;
            $display("FAIL done_once: got %0d pulses want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({ClrWe, ClrAddr, EdgeValid, EdgeX, EdgeY, Busy, Done, Overflow, FrameErr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got we=%b addr=%0d ev=%b busy=%b done=%b ovf=%b ferr=%b want all 0",
                     ClrWe, ClrAddr, EdgeValid, Busy, Done, Overflow, FrameErr);
        end
    endtask

    task automatic test_full_frame();
        int p0;
        start_pass();
        p0 = n_pops;
        send_frame(0, 1, 0);
        wait_done();
        n_chk++;
        if (n_pops - p0 != 1 || last_pop !== {2'd2, 1'b1} || FrameErr !== 1'b0 || Overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_frame: got pops=%0d last=%0h ferr=%b ovf=%b want pops=1 last=5 ferr=0 ovf=0",
                     n_pops - p0, last_pop, FrameErr, Overflow);
        end
    endtask

    task automatic test_backpressure();
        int p0, qd;
        start_pass();
        send_frame(1, 0, 0);
        qd = q.size();
        n_chk++;
        if (Overflow !== m_ovf || EdgeValid !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got ovf=%b ev=%b want ovf=%b ev=1", Overflow, EdgeValid, m_ovf);
        end
`ifndef HOUGH_ROI_EN
        n_chk++;
        if (qd != 4 || m_ovf != 1) begin
            n_err++;
            $display("FAIL model_fill: got %0d queued ovf=%b want 4 queued ovf=1", qd, m_ovf);
        end
`endif
        p0 = n_pops;
        wait_done();
        n_chk++;
        if (n_pops - p0 != qd) begin
            n_err++;
            $display("FAIL drain_pops: got %0d want %0d", n_pops - p0, qd);
        end
    endtask

    task automatic test_strobe_err();
        start_pass();
        cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1, 1, 0);
        n_chk++;
        if (FrameErr !== 1'b0) begin
            n_err++;
            $display("FAIL ferr_early: got %b want 0", FrameErr);
        end
        cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1, 0, 1);
        n_chk++;
        if (FrameErr !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_set: got %b want 1", FrameErr);
        end
        for (int x = 1; x < W; x++) cyc(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1, x, 1);
        wait_done();
        n_chk++;
        if (FrameErr !== 1'b1) begin
            n_err++;
            $display("FAIL ferr_sticky: got %b want 1", FrameErr);
        end
    endtask

    task automatic test_reset_mid_scan();
        int d0;
        start_pass();
        for (int x = 0; x < 3; x++) cyc(1'b1, x == 0, x == 0, 8'hFF, 1'b0, 1, x, 0);
        d0 = done_cnt;
        do_reset();
        n_chk++;
        if ({ClrWe, EdgeValid, EdgeX, EdgeY, Busy, Done, Overflow, FrameErr} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got ev=%b busy=%b done=%b want 0", EdgeValid, Busy, Done);
        end
        repeat (4) idle(1'b1);
        n_chk++;
        if (done_cnt != d0) begin
            n_err++;
            $display("FAIL mid_reset_done: got %0d pulses want 0", done_cnt - d0);
        end
        start_pass();
        send_frame(2, 2, 1);
        wait_done();
        n_chk++;
        if (FrameErr !== 1'b0 || Overflow !== m_ovf) begin
            n_err++;
            $display("FAIL after_reset_pass: got ferr=%b ovf=%b want ferr=0 ovf=%b", FrameErr, Overflow, m_ovf);
        end
    endtask

    task automatic test_random();
        repeat (4) begin
            repeat ($urandom_range(3)) cyc(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 0, 0, 0);
            start_pass();
            repeat ($urandom_range(3)) cyc(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 0, 0, 0);
            send_frame(2, 2, 1);
            wait_done();
            n_chk++;
            if (FrameErr !== 1'b0 || Overflow !== m_ovf) begin
                n_err++;
                $display("FAIL random_flags: got ferr=%b ovf=%b want ferr=0 ovf=%b", FrameErr, Overflow, m_ovf);
            end
        end
    endtask

`ifdef HOUGH_ROI_EN
    task automatic test_roi();
        int p0;
        start_pass();
        p0 = n_pops;
        send_frame(1, 1, 0);
        wait_done();
        n_chk++;
        if (n_pops - p0 != 4) begin
            n_err++;
            $display("FAIL roi_edges: got %0d want 4", n_pops - p0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_strobe_err();
        test_reset_mid_scan();
        test_random();
`ifdef HOUGH_ROI_EN
        test_roi();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/hough_scan_ctrl.md
Name: hough_scan_ctrl

Overview:
- Sequences one Hough frame pass.
- On Start, clears the vote accumulator, then waits for the next frame start on the input pixel stream.
- Tracks raster X/Y for every pixel, thresholds each pixel and queues edge coordinates in a small FIFO for the voting engine.
- Sits between the input pixel handler and the vote/accumulator engine. Signals completion once the frame is scanned and the FIFO has drained.

Parameters:
- WIDTH, 640: pixels per line.
- HEIGHT, 480: lines per frame.
- XW, 10: X coordinate width; must satisfy 2^XW >= WIDTH.
- YW, 9: Y coordinate width; must satisfy 2^YW >= HEIGHT.
- THRESH, 8'd128: edge threshold; a pixel is an edge when Pixel >= THRESH (unsigned).
- CLR_AW, 12: accumulator address width; the clear sweep covers 2^CLR_AW words.
- FIFO_DEPTH, 4: edge FIFO entries; must be a power of 2, >= 2.
- ROI_X0, 0 / ROI_X1, WIDTH-1: region-of-interest X bounds, used only with HOUGH_ROI_EN.

Ports:
- Clk  in  1  clock.
- nReset  in  1  reset; synchronous, active-low.
- Start  in  1  one-cycle request to begin a pass; honoured only in IDLE.
- Pixel  in  8  pixel intensity.
- PixValid  in  1  Pixel/Frame/Line are valid this cycle.
- Frame  in  1  qualified by PixValid; marks the first pixel of a frame.
- Line  in  1  qualified by PixValid; marks the first pixel of a line.
- ClrWe  out  1  accumulator clear write-enable.
- ClrAddr  out  CLR_AW  accumulator clear address.
- EdgeValid  out  1  FIFO head valid.
- EdgeX  out  XW  head X coordinate.
- EdgeY  out  YW  head Y coordinate.
- EdgeReady  in  1  voting engine accepts the head.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at end of pass.
- Overflow  out  1  sticky: an edge was dropped because the FIFO was full.
- FrameErr  out  1  sticky: raster strobe mismatch.

Behaviour:
- Reset (nReset low at a Clk edge): state IDLE, all outputs 0, FIFO emptied, counters 0. Reset mid-pass aborts the pass with no Done pulse.
- States:
  - IDLE: Start goes to CLEAR. Overflow and FrameErr clear on Start.
  - CLEAR: ClrWe=1 with ClrAddr = 0 .. 2^CLR_AW-1, one address per cycle. After the last address, go to WAIT_FRAME; ClrWe=0 from that cycle.
  - WAIT_FRAME: all pixels are ignored until PixValid&Frame. That pixel is (0,0) and is processed; go to SCAN.
  - SCAN: each PixValid pixel gets the current (x,y). Afterwards x increments. At x=WIDTH-1, x wraps to 0 and y increments. The pixel at (WIDTH-1,HEIGHT-1) is the last; go to DRAIN.
  - DRAIN: wait until the FIFO is empty, then go to DONE.
  - DONE: Done=1 for exactly one cycle; go to IDLE.
- Strobe checking in SCAN:
  - Line asserted when the predicted x != 0: set FrameErr and resync x=0, y=y+1.
  - Line not asserted when the predicted x == 0 (except the frame-start pixel): set FrameErr and continue counting.
  - Frame asserted mid-scan: set FrameErr and resync to (0,0).
  - Line on the first pixel of a frame is legal.
- Edge push: a pixel processed in WAIT_FRAME or SCAN with Pixel >= THRESH pushes {x,y}.
- Push timing: a pixel accepted at cycle N shows EdgeValid at cycle N+1 at the earliest, when the FIFO was empty.
- Pop: on EdgeValid&EdgeReady at a clock edge. EdgeX/EdgeY are held stable while EdgeValid=1 and EdgeReady=0.
- FIFO boundaries:
  - Push when full with no pop that cycle: the edge is dropped and Overflow=1.
  - Push and pop in the same cycle when full: both succeed; count unchanged.
  - Pop when empty: no effect.
  - The pass never stalls the input stream.
- Start while Busy: ignored.
- PixValid in IDLE, CLEAR or DONE: ignored.

Optional Feature:
- Macro: HOUGH_ROI_EN.
- Defined: an edge is pushed only if ROI_X0 <= x <= ROI_X1. Out-of-ROI pixels still advance the counters and strobe checking.
- Undefined: all threshold-passing pixels are pushed; ROI parameters are unused.

Test Plan:
- Use WIDTH=4, HEIGHT=2, CLR_AW=3 for all scenarios.
- Clear sweep: Start -> ClrWe high 8 consecutive cycles, ClrAddr 0..7, then state WAIT_FRAME, Busy=1.
- Full frame: 8 pixels with correct Frame/Line strobes, only pixel (2,1) = 8'hC0 and the rest 8'h10, EdgeReady=1 -> one edge EdgeX=2, EdgeY=1; Done pulses once; Busy falls with Done; FrameErr=0.
- Backpressure/overflow (FIFO_DEPTH=4): all 8 pixels = 8'hFF, EdgeReady=0 -> 4 entries queued, (0,0)..(3,0); Overflow=1. Then EdgeReady=1 -> 4 pops in order, then Done.
- Strobe error: Line asserted at predicted x=2 on line 0 -> FrameErr=1; the next pixel is (1,1).
- Reset mid-SCAN: nReset low one cycle -> next cycle all outputs 0, EdgeValid=0, no Done; a new Start runs a full pass cleanly.
- HOUGH_ROI_EN with ROI_X0=1, ROI_X1=2, all pixels 8'hFF, EdgeReady=1 -> edges only at x in {1,2}, 4 edges total; Done pulses.
